// File: rtl/cpu_step_ctrl.sv
// Clock-enable generator for the single-cycle CPU: debounced single-step button plus switch-selected auto-run.
// Define CPU_STEP_AUTOREPEAT_EN to repeat steps every REPEAT_CYCLES while the key stays held.
module cpu_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RUN_DIV         = 25000000,
  parameter int REPEAT_CYCLES   = 12500000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_n,
  input  logic             run_sw,
  output logic             step_en,
  output logic [CNT_W-1:0] step_count,
  output logic             btn_pressed,
  output logic             run_active
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int RW = $clog2(RUN_DIV);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] R_LAST = RW'(RUN_DIV - 1);

  if (DEBOUNCE_CYCLES < 2 || RUN_DIV < 2 || REPEAT_CYCLES < 2) begin : g_param_check
    $error("cpu_step_ctrl: DEBOUNCE_CYCLES, RUN_DIV and REPEAT_CYCLES must all be >= 2");
  end

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  state_t           r_state;
  logic             r_key_meta, r_key_s;
  logic             r_run_meta, r_run_s;
  logic [DW-1:0]    r_dcnt;
  logic [RW-1:0]    r_rcnt;
  logic             r_step_en;
  logic [CNT_W-1:0] r_step_count;
  logic             r_btn_pressed;
  logic             w_btn_step, w_div_wrap, w_rep_step, w_step_mode;

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_meta <= 1'b0;
      r_key_s    <= 1'b0;
      r_run_meta <= 1'b0;
      r_run_s    <= 1'b0;
    end else begin
      r_key_meta <= ~key_n;
      r_key_s    <= r_key_meta;
      r_run_meta <= run_sw;
      r_run_s    <= r_run_meta;
    end
  end

  assign w_btn_step = (r_state == PRESS_WAIT) && r_key_s && (r_dcnt == D_LAST);
  assign w_div_wrap = r_run_s && (r_rcnt == R_LAST);

`ifdef CPU_STEP_AUTOREPEAT_EN
  localparam int PW = $clog2(REPEAT_CYCLES);
  localparam logic [PW-1:0] P_LAST = PW'(REPEAT_CYCLES - 1);

  logic [PW-1:0] r_pcnt;
  logic          w_repeating;

  // The interval restarts whenever HELD is (re)entered because any other state clears it.
  assign w_repeating = (r_state == HELD) && !r_run_s;
  assign w_rep_step  = w_repeating && (r_pcnt == P_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcnt <= '0;
    end else if (!w_repeating || w_rep_step) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + PW'(1);
    end
  end
`else
  assign w_rep_step = 1'b0;
`endif

  assign w_step_mode = r_run_s ? w_div_wrap : (w_btn_step || w_rep_step);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rcnt       <= '0;
      r_step_en    <= 1'b0;
      r_step_count <= '0;
    end else begin
      r_rcnt       <= (!r_run_s || w_div_wrap) ? '0 : r_rcnt + RW'(1);
      // Suppressing back-to-back requests keeps the enable strictly one cycle wide across mode changes.
      r_step_en    <= w_step_mode && !r_step_en;
      r_step_count <= r_step_count + CNT_W'(r_step_en);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_dcnt        <= '0;
      r_btn_pressed <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_dcnt        <= '0;
          r_btn_pressed <= 1'b0;
          if (r_key_s) r_state <= PRESS_WAIT;
        end
        PRESS_WAIT: begin
          if (!r_key_s) begin
            r_state <= IDLE;
            r_dcnt  <= '0;
          end else if (r_dcnt == D_LAST) begin
            r_state       <= HELD;
            r_dcnt        <= '0;
            r_btn_pressed <= 1'b1;
          end else begin
            r_dcnt <= r_dcnt + DW'(1);
          end
        end
        HELD: begin
          r_dcnt        <= '0;
          r_btn_pressed <= 1'b1;
          if (!r_key_s) r_state <= RELEASE_WAIT;
        end
        RELEASE_WAIT: begin
          if (r_key_s) begin
            r_state <= HELD;
            r_dcnt  <= '0;
          end else if (r_dcnt == D_LAST) begin
            r_state       <= IDLE;
            r_dcnt        <= '0;
            r_btn_pressed <= 1'b0;
          end else begin
            r_dcnt <= r_dcnt + DW'(1);
          end
        end
        default: begin
          r_state       <= IDLE;
          r_dcnt        <= '0;
          r_btn_pressed <= 1'b0;
        end
      endcase
    end
  end

  assign step_en     = r_step_en;
  assign step_count  = r_step_count;
  assign btn_pressed = r_btn_pressed;
  assign run_active  = r_run_s;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: directed scenarios with hand-derived edge numbers plus random key/switch/reset
// traffic, all compared every cycle against a run-length model of the debounce and step rules.
module tb_cpu_step_ctrl;

  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 16;
  localparam int CW = 4;
`ifdef CPU_STEP_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          key_n = 1'b1;
  logic          run_sw = 1'b0;
  logic          step_en;
  logic [CW-1:0] step_count;
  logic          btn_pressed;
  logic          run_active;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_no  = 0;
  int pulse_at[$];

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .RUN_DIV        (RD),
    .REPEAT_CYCLES  (RP),
    .CNT_W          (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_n      (key_n),
    .run_sw     (run_sw),
    .step_en    (step_en),
    .step_count (step_count),
    .btn_pressed(btn_pressed),
    .run_active (run_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: the debouncer is expressed as run lengths of the synchronized key level, the
  // divider and repeat as edge counts taken modulo their period.
  bit m_key_hist[2];
  bit m_run_hist[2];
  bit m_pressed;
  int m_ones, m_zeros, m_run_edges, m_hold_edges, m_count;
  bit m_step;

  always @(posedge clk or posedge rst) begin : model
    bit ks, rs, press_evt, rep_evt, wrap_evt, nx_pressed;
    int nx_ones, nx_zeros, nx_run, nx_hold;
    if (rst) begin
      m_key_hist[0] <= 1'b0; m_key_hist[1] <= 1'b0;
      m_run_hist[0] <= 1'b0; m_run_hist[1] <= 1'b0;
      m_pressed <= 1'b0; m_ones <= 0; m_zeros <= 0;
      m_run_edges <= 0; m_hold_edges <= 0; m_step <= 1'b0; m_count <= 0;
    end else begin
      ks = m_key_hist[1];
      rs = m_run_hist[1];
      press_evt = 1'b0; rep_evt = 1'b0;
      nx_pressed = m_pressed; nx_ones = 0; nx_zeros = 0;
      if (!m_pressed) begin
        nx_ones = ks ? m_ones + 1 : 0;
        if (nx_ones == D + 1) begin nx_pressed = 1'b1; nx_ones = 0; press_evt = 1'b1; end
      end else begin
        nx_zeros = ks ? 0 : m_zeros + 1;
        if (nx_zeros == D + 1) begin nx_pressed = 1'b0; nx_zeros = 0; end
      end
      nx_run   = rs ? m_run_edges + 1 : 0;
      wrap_evt = rs && (nx_run % RD == 0);
      nx_hold  = 0;
      if (AR && m_pressed && m_zeros == 0 && !rs) begin
        nx_hold = m_hold_edges + 1;
        rep_evt = (nx_hold % RP == 0);
      end
      m_step        <= (rs ? wrap_evt : (press_evt || rep_evt)) && !m_step;
      m_count       <= (m_count + int'(m_step)) % (1 << CW);
      m_pressed     <= nx_pressed;
      m_ones        <= nx_ones;
      m_zeros       <= nx_zeros;
      m_run_edges   <= nx_run;
      m_hold_edges  <= nx_hold;
      m_key_hist[1] <= m_key_hist[0];
      m_key_hist[0] <= ~key_n;
      m_run_hist[1] <= m_run_hist[0];
      m_run_hist[0] <= run_sw;
    end
  end

  always @(posedge clk) begin
    #1;
    check("cmp_step_en",     step_en,     m_step);
    check("cmp_step_count",  step_count,  m_count);
    check("cmp_btn_pressed", btn_pressed, m_pressed);
    check("cmp_run_active",  run_active,  m_run_hist[1]);
  end

  task automatic tick();
    @(posedge clk);
    #2;
    edge_no++;
    if (step_en) pulse_at.push_back(edge_no);
  endtask

  task automatic do_reset();
    key_n = 1'b1; run_sw = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    edge_no = 0;
    pulse_at.delete();
  endtask

  initial begin
    #2 rst = 1'b1;
    tick();
    check("rst_step_en", step_en, 0);
    check("rst_step_count", step_count, 0);
    check("rst_btn_pressed", btn_pressed, 0);
    check("rst_run_active", run_active, 0);
    tick();
    rst = 1'b0;

    // 1: clean press, 30 cycles low
    edge_no = 0; pulse_at.delete();
    key_n = 1'b0;
    for (int e = 1; e <= 50; e++) begin
      tick();
      if (e <= 30) check("t1_step_en", step_en, (e == 7) || (AR && e == 23));
      if (e == 6 || e == 7 || e == 36 || e == 37) check("t1_btn_pressed", btn_pressed, e >= 7 && e <= 36);
      if (e == 30) key_n = 1'b1;
    end
    check("t1_step_count", step_count, AR ? 2 : 1);

    // 2a: press bounce is rejected
    for (int e = 0; e < 15; e++) begin
      key_n = (e == 2) || (e >= 5);
      tick();
      check("t2_bounce_step_en", step_en, 0);
      check("t2_bounce_btn", btn_pressed, 0);
    end
    check("t2_bounce_count", step_count, AR ? 2 : 1);

    // 2b: release bounce while held is absorbed
    edge_no = 0; pulse_at.delete();
    for (int e = 1; e <= 39; e++) begin
      key_n = !(e <= 12 || (e >= 15 && e <= 19));
      tick();
      if (e >= 6 && e <= 27) check("t2_hold_btn", btn_pressed, e >= 7 && e <= 25);
    end
    check("t2_rel_pulses", pulse_at.size(), 1);
    if (pulse_at.size() > 0) check("t2_rel_pulse_edge", pulse_at[0], 7);
    check("t2_rel_count", step_count, AR ? 3 : 2);

    // 3: run mode with a masked key press
    edge_no = 0; pulse_at.delete();
    for (int e = 1; e <= 60; e++) begin
      key_n  = !(e >= 5 && e <= 20);
      run_sw = (e <= 40);
      tick();
      if (e == 1 || e == 2 || e == 41 || e == 42) check("t3_run_active", run_active, e == 2 || e == 41);
      if (e == 11) check("t3_btn_masked", btn_pressed, 1);
    end
    check("t3_pulse_cnt_ok", pulse_at.size() >= 4 && pulse_at.size() <= 5, 1);
    if (pulse_at.size() > 0) begin
      check("t3_first_pulse", pulse_at[0], 10);
      check("t3_last_pulse_le42", pulse_at[pulse_at.size()-1] <= 42, 1);
    end
    for (int i = 1; i < pulse_at.size(); i++) check("t3_spacing", pulse_at[i] - pulse_at[i-1], RD);
    check("t3_count", step_count, AR ? 8 : 7);

    // 4: counter wrap across 17 presses
    do_reset();
    for (int i = 0; i < 17; i++) begin
      key_n = 1'b0;
      repeat (8) tick();
      key_n = 1'b1;
      repeat (10) tick();
      check("t4_step_count", step_count, (i + 1) % 16);
    end

    // 5: reset during PRESS_WAIT with key kept low
    do_reset();
    key_n = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_rst_step_en", step_en, 0);
      check("t5_rst_btn", btn_pressed, 0);
      check("t5_rst_count", step_count, 0);
      check("t5_rst_run", run_active, 0);
    end
    rst = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      check("t5_step_en", step_en, e == 7);
    end
    key_n = 1'b1;
    repeat (12) tick();

    // 6: long hold, one step or auto-repeat
    do_reset();
    key_n = 1'b0;
    repeat (60) tick();
    key_n = 1'b1;
    repeat (15) tick();
    check("t6_pulses", pulse_at.size(), AR ? 4 : 1);
    for (int i = 0; i < pulse_at.size() && i < 4; i++) check("t6_pulse_edge", pulse_at[i], 7 + 16 * i);

    // Random traffic against the model
    do_reset();
    for (int seg = 0; seg < 300; seg++) begin
      key_n = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) run_sw = ~run_sw;
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 2)) tick();
        rst = 1'b0;
      end
      repeat ($urandom_range(1, 20)) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
